// File: rtl/coeff_load_pkg.sv
// rtl/coeff_load_pkg.sv - shared sizing constants and FSM encoding for the coefficient loader
package coeff_load_pkg;

  localparam int TOTAL_TAPS    = 33;
  localparam int TAPS_PER_BANK = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLAG  = 3'd1,
    FETCH = 3'd2,
    WRITE = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/coeff_slot_map.sv
// rtl/coeff_slot_map.sv - maps a 1-based slot number to filter RAM bank and 1-based in-bank address
module coeff_slot_map
  import coeff_load_pkg::*;
#(
  parameter int TAPS_PER_BANK = coeff_load_pkg::TAPS_PER_BANK
) (
  input  logic [5:0] slot,
  output logic [1:0] bankSel,
  output logic [3:0] bankAddr
);

  logic [5:0] slotIdx;

  // Slot 0 never reaches a WRITE cycle, so the wrap of slotIdx there is harmless
  always_comb begin
    slotIdx  = slot - 6'd1;
    bankSel  = 2'(slotIdx / 6'(TAPS_PER_BANK));
    bankAddr = 4'((slotIdx % 6'(TAPS_PER_BANK)) + 6'd1);
  end

endmodule

// File: rtl/coeff_load_master.sv
// rtl/coeff_load_master.sv - streams a coefficient table into the banked filter RAM, zero-filling unused taps
module coeff_load_master
  import coeff_load_pkg::*;
#(
  parameter int TOTAL_TAPS    = coeff_load_pkg::TOTAL_TAPS,
  parameter int TAPS_PER_BANK = coeff_load_pkg::TAPS_PER_BANK
) (
  input  logic               iClk_12M,
  input  logic               iRst,
  input  logic               iStart,
  input  logic [5:0]         iNumOfCoeff,
  output logic [5:0]         oTabAddr,
  output logic               oTabRd,
  input  logic signed [15:0] iTabData,
  output logic               oCoeffiUpdateFlag,
  output logic               oCsnRam,
  output logic               oWrnRam,
  output logic [1:0]         oBankSel,
  output logic [3:0]         oAddrRam,
  output logic signed [15:0] oWrDtRam,
  output logic               oBusy,
  output logic               oDone
);

  localparam logic [5:0] LAST_SLOT = 6'(TOTAL_TAPS);

  state_t     state, stateNext;
  logic [5:0] slot, slotNext;
  logic [5:0] neff, neffNext;
  logic       useData, useDataNext;

  logic [5:0] tabAddrNext;
  logic       tabRdNext, flagNext, csnNext, wrnNext, busyNext, doneNext;
  logic [1:0] bankNext, mapBank;
  logic [3:0] addrNext, mapAddr;

  coeff_slot_map #(
    .TAPS_PER_BANK(TAPS_PER_BANK)
  ) slotMap (
    .slot    (slot),
    .bankSel (mapBank),
    .bankAddr(mapAddr)
  );

  // Next state, slot counter and clamped tap count, then the output values for the state being entered
  always_comb begin
    stateNext   = state;
    slotNext    = slot;
    neffNext    = neff;
    tabRdNext   = 1'b0;
    tabAddrNext = 6'd0;
    flagNext    = 1'b0;
    csnNext     = 1'b1;
    wrnNext     = 1'b1;
    bankNext    = 2'd0;
    addrNext    = 4'd0;
    useDataNext = 1'b0;
    busyNext    = 1'b0;
    doneNext    = 1'b0;

    case (state)
      IDLE: begin
        if (iStart) begin
          stateNext = FLAG;
          neffNext  = (iNumOfCoeff > LAST_SLOT) ? LAST_SLOT : iNumOfCoeff;
        end
      end
      FLAG: begin
        stateNext = FETCH;
        slotNext  = 6'd1;
      end
      FETCH:   stateNext = WRITE;
      WRITE:   stateNext = GAP;
      GAP: begin
        if (slot < LAST_SLOT) begin
          stateNext = FETCH;
          slotNext  = slot + 6'd1;
        end else begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
        slotNext  = 6'd0;
      end
      default: stateNext = IDLE;
    endcase

    // Outputs are decided one cycle early so every port comes straight off a flop
    case (stateNext)
      FLAG, GAP: begin
        flagNext = 1'b1;
        busyNext = 1'b1;
      end
      FETCH: begin
        flagNext = 1'b1;
        busyNext = 1'b1;
        if (slotNext <= neffNext) begin
          tabRdNext   = 1'b1;
          tabAddrNext = slotNext - 6'd1;
        end
      end
      WRITE: begin
        flagNext    = 1'b1;
        busyNext    = 1'b1;
        csnNext     = 1'b0;
        wrnNext     = 1'b0;
        bankNext    = mapBank;
        addrNext    = mapAddr;
        useDataNext = (slot <= neff);
      end
      DONE: begin
        busyNext = 1'b1;
        doneNext = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs; reset drops any load in progress
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state             <= IDLE;
      slot              <= 6'd0;
      neff              <= 6'd0;
      useData           <= 1'b0;
      oTabRd            <= 1'b0;
      oTabAddr          <= 6'd0;
      oCoeffiUpdateFlag <= 1'b0;
      oCsnRam           <= 1'b1;
      oWrnRam           <= 1'b1;
      oBankSel          <= 2'd0;
      oAddrRam          <= 4'd0;
      oBusy             <= 1'b0;
      oDone             <= 1'b0;
    end else begin
      state             <= stateNext;
      slot              <= slotNext;
      neff              <= neffNext;
      useData           <= useDataNext;
      oTabRd            <= tabRdNext;
      oTabAddr          <= tabAddrNext;
      oCoeffiUpdateFlag <= flagNext;
      oCsnRam           <= csnNext;
      oWrnRam           <= wrnNext;
      oBankSel          <= bankNext;
      oAddrRam          <= addrNext;
      oBusy             <= busyNext;
      oDone             <= doneNext;
    end
  end

  // Table data only arrives in the WRITE cycle itself, so it is gated by a registered select rather than re-flopped
  always_comb begin
    oWrDtRam = useData ? iTabData : 16'sd0;
  end

endmodule

// File: tb/tb_coeff_load_master.sv
// tb/tb_coeff_load_master.sv - directed self-checking bench for coeff_load_master
`timescale 1ns/1ps

module tb_coeff_load_master;

  logic               clk;
  logic               iRst;
  logic               iStart;
  logic [5:0]         iNumOfCoeff;
  logic [5:0]         oTabAddr;
  logic               oTabRd;
  logic signed [15:0] iTabData;
  logic               oCoeffiUpdateFlag;
  logic               oCsnRam;
  logic               oWrnRam;
  logic [1:0]         oBankSel;
  logic [3:0]         oAddrRam;
  logic signed [15:0] oWrDtRam;
  logic               oBusy;
  logic               oDone;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] tbl [64];
  time t0 = 0;

  logic [1:0]  wrBank [512];
  logic [3:0]  wrAddr [512];
  logic [15:0] wrData [512];
  int          wrCyc  [512];
  logic [5:0]  rdAddrLog [512];
  int wrCount = 0;
  int rdCount = 0;
  int doneCount = 0;
  int strobeErr = 0;
  logic prevCsn = 1'b1;

  int wb, rb, db, doneAt;

  coeff_load_master dut (
    .iClk_12M         (clk),
    .iRst             (iRst),
    .iStart           (iStart),
    .iNumOfCoeff      (iNumOfCoeff),
    .oTabAddr         (oTabAddr),
    .oTabRd           (oTabRd),
    .iTabData         (iTabData),
    .oCoeffiUpdateFlag(oCoeffiUpdateFlag),
    .oCsnRam          (oCsnRam),
    .oWrnRam          (oWrnRam),
    .oBankSel         (oBankSel),
    .oAddrRam         (oAddrRam),
    .oWrDtRam         (oWrDtRam),
    .oBusy            (oBusy),
    .oDone            (oDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial iTabData = 16'sd0;
  always @(posedge clk) if (oTabRd === 1'b1) iTabData <= tbl[oTabAddr];

  function automatic int curCycle();
    return int'(($time - t0) / 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (oCsnRam === 1'b0) begin
      wrBank[wrCount] = oBankSel;
      wrAddr[wrCount] = oAddrRam;
      wrData[wrCount] = oWrDtRam;
      wrCyc[wrCount]  = curCycle();
      wrCount++;
      if (prevCsn === 1'b0) strobeErr++;
    end else if (oWrDtRam !== 16'sd0 || oAddrRam !== 4'd0 || oBankSel !== 2'd0) begin
      strobeErr++;
    end
    if (oWrnRam !== oCsnRam) strobeErr++;
    if (oTabRd === 1'b1) begin
      rdAddrLog[rdCount] = oTabAddr;
      rdCount++;
    end
    if (oDone === 1'b1) doneCount++;
    prevCsn = oCsnRam;
  end

  task automatic startLoad(input logic [5:0] n);
    @(negedge clk);
    iNumOfCoeff = n;
    iStart = 1'b1;
    wb = wrCount;
    rb = rdCount;
    db = doneCount;
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic waitDone(output int at);
    at = -1;
    for (int i = 0; i < 200 && at < 0; i++) begin
      if (oDone === 1'b1) at = curCycle();
      else @(negedge clk);
    end
    if (at < 0) begin
      errors++;
      $error("FAIL timeout waiting for oDone");
    end
  endtask

  task automatic toCycle(input int c);
    for (int i = 0; i < 200 && curCycle() < c; i++) @(negedge clk);
  endtask

  task automatic checkRun(input string name, input int neffExp, input int at, input int rdExp, input int maxAddrExp);
    logic [15:0] exp;
    int mx;
    @(negedge clk);
    chk({name, " done cycle"}, at, 100);
    chk({name, " done pulses"}, doneCount - db, 1);
    chk({name, " write count"}, wrCount - wb, 33);
    chk({name, " read count"}, rdCount - rb, rdExp);
    mx = -1;
    for (int j = rb; j < rdCount; j++) if (int'(rdAddrLog[j]) > mx) mx = int'(rdAddrLog[j]);
    chk({name, " max table addr"}, mx, maxAddrExp);
    for (int k = 1; k <= 33; k++) begin
      exp = (k <= neffExp) ? tbl[k-1] : 16'd0;
      chk($sformatf("%s slot%0d data", name, k), wrData[wb+k-1], exp);
    end
  endtask

  initial begin
    iRst = 1'b1;
    iStart = 1'b0;
    iNumOfCoeff = 6'd0;
    for (int i = 0; i < 64; i++) tbl[i] = 16'(i + 1);
    repeat (3) @(negedge clk);

    chk("reset csn", oCsnRam, 1'b1);
    chk("reset wrn", oWrnRam, 1'b1);
    chk("reset flag", oCoeffiUpdateFlag, 1'b0);
    chk("reset busy", oBusy, 1'b0);
    chk("reset done", oDone, 1'b0);
    chk("reset tabrd", oTabRd, 1'b0);
    chk("reset tabaddr", oTabAddr, 6'd0);
    chk("reset bank", oBankSel, 2'd0);
    chk("reset addr", oAddrRam, 4'd0);
    chk("reset data", oWrDtRam, 16'd0);
    iRst = 1'b0;

    // Full load N=33 with table[i]=i+1
    startLoad(6'd33);
    chk("n33 cycle0 flag", oCoeffiUpdateFlag, 1'b1);
    chk("n33 cycle0 busy", oBusy, 1'b1);
    chk("n33 cycle0 csn", oCsnRam, 1'b1);
    waitDone(doneAt);
    chk("n33 done flag low", oCoeffiUpdateFlag, 1'b0);
    chk("n33 done busy", oBusy, 1'b1);
    checkRun("n33", 33, doneAt, 33, 32);
    chk("n33 after busy", oBusy, 1'b0);
    chk("n33 after done", oDone, 1'b0);
    chk("n33 slot1 bank", wrBank[wb+0], 2'd0);
    chk("n33 slot1 addr", wrAddr[wb+0], 4'd1);
    chk("n33 slot1 cycle", wrCyc[wb+0], 2);
    chk("n33 slot10 bank", wrBank[wb+9], 2'd0);
    chk("n33 slot10 addr", wrAddr[wb+9], 4'd10);
    chk("n33 slot11 bank", wrBank[wb+10], 2'd1);
    chk("n33 slot11 addr", wrAddr[wb+10], 4'd1);
    chk("n33 slot25 bank", wrBank[wb+24], 2'd2);
    chk("n33 slot25 addr", wrAddr[wb+24], 4'd5);
    chk("n33 slot33 bank", wrBank[wb+32], 2'd3);
    chk("n33 slot33 addr", wrAddr[wb+32], 4'd3);
    chk("n33 slot33 data", wrData[wb+32], 16'd33);
    chk("n33 slot33 cycle", wrCyc[wb+32], 98);

    // N=5 with negative table values: five reads, zero fill for slots 6..33
    for (int i = 0; i < 64; i++) tbl[i] = 16'(-(i + 1) * 100);
    startLoad(6'd5);
    waitDone(doneAt);
    checkRun("n5", 5, doneAt, 5, 4);
    chk("n5 slot1 data", wrData[wb+0], 16'hFF9C);
    chk("n5 slot5 data", wrData[wb+4], 16'hFE0C);
    chk("n5 slot6 data", wrData[wb+5], 16'h0000);

    // N=0: every slot zero-filled, no reads
    for (int i = 0; i < 64; i++) tbl[i] = 16'(i + 1);
    startLoad(6'd0);
    waitDone(doneAt);
    checkRun("n0", 0, doneAt, 0, -1);

    // N=40 clamps to 33
    startLoad(6'd40);
    waitDone(doneAt);
    checkRun("n40", 33, doneAt, 33, 32);

    // Re-pulsed iStart and changed count mid-load are ignored
    startLoad(6'd33);
    toCycle(50);
    iStart = 1'b1;
    iNumOfCoeff = 6'd2;
    toCycle(51);
    iStart = 1'b0;
    waitDone(doneAt);
    checkRun("restart", 33, doneAt, 33, 32);
    repeat (5) @(negedge clk);
    chk("restart no relaunch", oBusy, 1'b0);

    // Reset in cycle 40 (slot 14 FETCH) aborts after 13 writes, no done pulse
    startLoad(6'd33);
    toCycle(40);
    iRst = 1'b1;
    toCycle(41);
    chk("abort csn", oCsnRam, 1'b1);
    chk("abort flag", oCoeffiUpdateFlag, 1'b0);
    chk("abort busy", oBusy, 1'b0);
    chk("abort tabrd", oTabRd, 1'b0);
    iRst = 1'b0;
    repeat (120) @(negedge clk);
    chk("abort writes", wrCount - wb, 13);
    chk("abort reads", rdCount - rb, 14);
    chk("abort done pulses", doneCount - db, 0);

    // Clean full load after the abort
    startLoad(6'd33);
    waitDone(doneAt);
    checkRun("postabort", 33, doneAt, 33, 32);
    chk("postabort slot1 bank", wrBank[wb+0], 2'd0);
    chk("postabort slot1 addr", wrAddr[wb+0], 4'd1);

    chk("strobe shape", strobeErr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
